// File: rtl/lm70_pkg.sv
// lm70_pkg: frame layout constants and FSM state encoding shared by the LM70 reader
package lm70_pkg;
  localparam int LM70_FRAME_W = 16;
  localparam int LM70_CODE_W = 11;
  localparam int LM70_INT_W = 9;
  localparam logic [2:0] LM70_FIXED_BITS = 3'b111;
  localparam int LM70_FIXED_MSB = 4;
  localparam int LM70_FIXED_LSB = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;
endpackage

// File: rtl/lm70_sck_gen.sv
// lm70_sck_gen: free-running half-period divider with rise/fall strobes and the sck register
module lm70_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sck
);
  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
  logic [15:0] cnt;
  assign tick = cnt == LAST;
  assign rise = tick & en & ~sck;
  assign fall = tick & en & sck;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else begin
      cnt <= (clr | tick) ? '0 : cnt + 16'd1;
      sck <= clr ? 1'b0 : (tick & en) ? ~sck : sck;
    end
endmodule

// File: rtl/lm70_spi_reader.sv
// lm70_spi_reader: LM70 3-wire SPI frame reader with temperature decode, optional poll and alarm
// Optional hysteresis alarm enabled by defining LM70_ALARM_EN; otherwise alarm is tied low.
module lm70_spi_reader
  import lm70_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int POLL_CYCLES = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic                           start,
  input  logic                           sio_in,
  input  logic [LM70_CODE_W-1:0]         thr_hi,
  input  logic [LM70_CODE_W-1:0]         thr_lo,
  output logic                           cs_n,
  output logic                           sck,
  output logic                           busy,
  output logic [LM70_FRAME_W-1:0]        frame,
  output logic [LM70_CODE_W-1:0]         temp_code,
  output logic [LM70_INT_W-1:0]          temp_int,
  output logic                           temp_valid,
  output logic                           frame_err,
  output logic                           alarm
);
  localparam logic [31:0] POLL_LAST = (POLL_CYCLES > 0) ? 32'(POLL_CYCLES - 1) : 32'd0;
  logic [1:0] state;
  logic [4:0] bits;
  logic [LM70_FRAME_W-1:0] sr;
  logic [31:0] poll_cnt;
  logic pend, gap_ok, tick, rise, fall, go, done, poll_tick, frame_ok;
  assign poll_tick = (POLL_CYCLES > 0) && ena && (poll_cnt == POLL_LAST);
  assign go = (state == ST_IDLE) && ena && (start || poll_tick || pend) && (gap_ok || tick);
  assign done = (state == ST_HOLD) && tick;
  assign frame_ok = sr[LM70_FIXED_MSB:LM70_FIXED_LSB] == LM70_FIXED_BITS;
  lm70_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (go),
    .en   (state == ST_SETUP || state == ST_SHIFT),
    .tick (tick),
    .rise (rise),
    .fall (fall),
    .sck  (sck)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      bits <= '0;
      sr <= '0;
      poll_cnt <= '0;
      pend <= 1'b0;
      gap_ok <= 1'b1;
      cs_n <= 1'b1;
      busy <= 1'b0;
      frame <= '0;
      temp_code <= '0;
      temp_int <= '0;
      temp_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= go ? ST_SETUP
             : (state == ST_SETUP && rise) ? ST_SHIFT
             : (state == ST_SHIFT && fall && bits == 5'd16) ? ST_HOLD
             : done ? ST_IDLE : state;
      bits <= go ? '0 : rise ? bits + 5'd1 : bits;
      sr <= rise ? {sr[LM70_FRAME_W-2:0], sio_in} : sr;
      // poll period restarts at every frame start, whatever triggered it
      poll_cnt <= (go || poll_tick) ? '0 : ena ? poll_cnt + 32'd1 : poll_cnt;
      pend <= go ? 1'b0 : poll_tick ? 1'b1 : pend;
      gap_ok <= done ? 1'b0 : (state == ST_IDLE && tick) ? 1'b1 : gap_ok;
      cs_n <= go ? 1'b0 : done ? 1'b1 : cs_n;
      busy <= go ? 1'b1 : done ? 1'b0 : busy;
      temp_valid <= done & frame_ok;
      if (done) begin
        frame <= sr;
        frame_err <= ~frame_ok;
      end
      if (done && frame_ok) begin
        temp_code <= sr[LM70_FRAME_W-1 -: LM70_CODE_W];
        temp_int <= sr[LM70_FRAME_W-1 -: LM70_INT_W];
      end
    end
`ifdef LM70_ALARM_EN
  logic signed [LM70_CODE_W-1:0] code_new;
  assign code_new = $signed(sr[LM70_FRAME_W-1 -: LM70_CODE_W]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) alarm <= 1'b0;
    else if (done && frame_ok)
      alarm <= (code_new >= $signed(thr_hi)) ? 1'b1 : (code_new <= $signed(thr_lo)) ? 1'b0 : alarm;
`else
  logic unused_thr;
  assign unused_thr = ^{thr_hi, thr_lo};
  assign alarm = 1'b0;
`endif
endmodule

// File: tb/tb_lm70_spi_reader.sv
// tb_lm70_spi_reader: directed table-driven bench with behavioural LM70 responders
module tb_lm70_spi_reader;
`ifdef LM70_ALARM_EN
  localparam logic AEN = 1'b1;
`else
  localparam logic AEN = 1'b0;
`endif
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic rst_n, ena, start, sio;
  logic [10:0] thr_hi = 11'd200, thr_lo = 11'd160;
  logic cs_n, sck, busy, temp_valid, frame_err, alarm;
  logic [15:0] frame;
  logic [10:0] temp_code;
  logic [8:0] temp_int;
  logic rst_pn, ena_p, sio_p;
  logic start_p = 1'b0;
  logic cs_n_p, sck_p, busy_p, temp_valid_p, frame_err_p, alarm_p;
  logic [15:0] frame_p;
  logic [10:0] temp_code_p;
  logic [8:0] temp_int_p;
  lm70_spi_reader #(.CLK_DIV(2), .POLL_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .sio_in(sio),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .cs_n(cs_n), .sck(sck), .busy(busy),
    .frame(frame), .temp_code(temp_code), .temp_int(temp_int),
    .temp_valid(temp_valid), .frame_err(frame_err), .alarm(alarm)
  );
  lm70_spi_reader #(.CLK_DIV(2), .POLL_CYCLES(100)) dut_p (
    .clk(clk), .rst_n(rst_pn), .ena(ena_p), .start(start_p), .sio_in(sio_p),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .cs_n(cs_n_p), .sck(sck_p), .busy(busy_p),
    .frame(frame_p), .temp_code(temp_code_p), .temp_int(temp_int_p),
    .temp_valid(temp_valid_p), .frame_err(frame_err_p), .alarm(alarm_p)
  );
  // sensor model: D15 driven at cs_n fall, next bit presented after each sck fall
  logic [15:0] word = 16'h0000;
  int idx = 0, idx_p = 0;
  always @(negedge sck or posedge cs_n) idx <= cs_n ? 0 : idx + 1;
  always @(negedge sck_p or posedge cs_n_p) idx_p <= cs_n_p ? 0 : idx_p + 1;
  assign sio = (idx < 16) ? word[4'(15 - idx)] : 1'b0;
  logic [15:0] word_p = 16'h0C9F;
  assign sio_p = (idx_p < 16) ? word_p[4'(15 - idx_p)] : 1'b0;
  int cyc = 0;
  logic pcs = 1'b1;
  int falls[$], rises[$];
  always @(negedge clk) begin
    cyc++;
    if (pcs && !cs_n_p) falls.push_back(cyc);
    if (!pcs && cs_n_p) rises.push_back(cyc);
    pcs = cs_n_p;
  end
  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic run_frame(input logic [15:0] w, output int lows, output int pulses, output int vld);
    logic psck;
    lows = 0; pulses = 0; vld = 0; psck = 1'b0;
    word = w;
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk) start = 1'b0;
      if (!cs_n) lows++;
      if (sck && !psck) pulses++;
      psck = sck;
      if (temp_valid) vld++;
    end
  endtask
  typedef struct {
    logic [15:0] word;
    logic [10:0] code;
    logic [8:0]  tint;
    logic        err;
    logic        alarm;
  } vec_t;
  vec_t vecs[12];
  initial begin
    int lows, pulses, vld, n;
    vecs[0]  = '{16'h0C9F, 11'h064, 9'h019, 1'b0, 1'b0};
    vecs[1]  = '{16'hF39F, 11'h79C, 9'h1E7, 1'b0, 1'b0};
    vecs[2]  = '{16'h0C8F, 11'h79C, 9'h1E7, 1'b1, 1'b0};
    vecs[3]  = '{16'hFFFF, 11'h7FF, 9'h1FF, 1'b0, 1'b0};
    vecs[4]  = '{16'hFFBF, 11'h7FD, 9'h1FF, 1'b0, 1'b0};
    vecs[5]  = '{16'h007F, 11'h003, 9'h000, 1'b0, 1'b0};
    vecs[6]  = '{16'h1A1F, 11'h0D0, 9'h034, 1'b0, 1'b1};
    vecs[7]  = '{16'h169F, 11'h0B4, 9'h02D, 1'b0, 1'b1};
    vecs[8]  = '{16'h1317, 11'h0B4, 9'h02D, 1'b1, 1'b1};
    vecs[9]  = '{16'h131F, 11'h098, 9'h026, 1'b0, 1'b0};
    vecs[10] = '{16'h191F, 11'h0C8, 9'h032, 1'b0, 1'b1};
    vecs[11] = '{16'h141F, 11'h0A0, 9'h028, 1'b0, 1'b0};
    rst_n = 1'b0; rst_pn = 1'b0; ena = 1'b1; ena_p = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst cs_n", 32'(cs_n), 32'd1);
    chk("rst sck", 32'(sck), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst frame", 32'(frame), 32'd0);
    chk("rst valid", 32'(temp_valid), 32'd0);
    chk("rst alarm", 32'(alarm), 32'd0);
    rst_n = 1'b1; rst_pn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      run_frame(vecs[i].word, lows, pulses, vld);
      chk($sformatf("v%0d cs_low", i), 32'(lows), 32'd66);
      chk($sformatf("v%0d sck_pulses", i), 32'(pulses), 32'd16);
      chk($sformatf("v%0d frame", i), 32'(frame), 32'(vecs[i].word));
      chk($sformatf("v%0d temp_code", i), 32'(temp_code), 32'(vecs[i].code));
      chk($sformatf("v%0d temp_int", i), 32'(temp_int), 32'(vecs[i].tint));
      chk($sformatf("v%0d frame_err", i), 32'(frame_err), 32'(vecs[i].err));
      chk($sformatf("v%0d valid_count", i), 32'(vld), vecs[i].err ? 32'd0 : 32'd1);
      chk($sformatf("v%0d alarm", i), 32'(alarm), 32'(vecs[i].alarm & AEN));
    end
    word = 16'h0C9F;
    @(negedge clk) start = 1'b1;
    repeat (20) @(negedge clk) start = 1'b0;
    chk("mid cs_n", 32'(cs_n), 32'd0);
    chk("mid sck", 32'(sck), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst cs_n", 32'(cs_n), 32'd1);
    chk("arst sck", 32'(sck), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst frame", 32'(frame), 32'd0);
    chk("arst temp_code", 32'(temp_code), 32'd0);
    chk("arst temp_int", 32'(temp_int), 32'd0);
    chk("arst frame_err", 32'(frame_err), 32'd0);
    chk("arst alarm", 32'(alarm), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_frame(16'h0C9F, lows, pulses, vld);
    chk("post cs_low", 32'(lows), 32'd66);
    chk("post sck_pulses", 32'(pulses), 32'd16);
    chk("post frame", 32'(frame), 32'h0C9F);
    chk("post temp_int", 32'(temp_int), 32'd25);
    chk("post valid_count", 32'(vld), 32'd1);
    ena_p = 1'b1;
    n = 0;
    while (falls.size() < 4 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("poll falls", 32'(falls.size()), 32'd4);
    if (falls.size() >= 4) begin
      chk("poll period 1", 32'(falls[1] - falls[0]), 32'd100);
      chk("poll period 2", 32'(falls[2] - falls[1]), 32'd100);
      chk("poll period 3", 32'(falls[3] - falls[2]), 32'd100);
    end
    chk("poll frame", 32'(frame_p), 32'h0C9F);
    chk("poll temp_code", 32'(temp_code_p), 32'd100);
    repeat (10) @(negedge clk);
    ena_p = 1'b0;
    repeat (300) @(negedge clk);
    chk("ena-off falls", 32'(falls.size()), 32'd4);
    chk("ena-off rises", 32'(rises.size()), 32'd4);
    if (falls.size() >= 4 && rises.size() >= 4)
      chk("ena-off last frame len", 32'(rises[3] - falls[3]), 32'd66);
    chk("ena-off cs_n", 32'(cs_n_p), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
